// File: rtl/jtag_bitbang_bridge.sv
// OpenOCD remote_bitbang byte stream to JTAG pins, with paced execution and TDO responses.
// Build option JTAG_BLINK_EN: when defined, 'B'/'b' drive led_o; otherwise led_o is tied low.
module jtag_bitbang_bridge #(
    parameter int unsigned CMD_FIFO_DEPTH = 16,
    parameter int unsigned RSP_FIFO_DEPTH = 8,
    parameter int unsigned TICK_DELAY     = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    input  logic [7:0] cmd_data_i,
    output logic       cmd_ready_o,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    input  logic       rsp_ready_i,
    output logic       jtag_tck_o,
    output logic       jtag_tms_o,
    output logic       jtag_tdi_o,
    output logic       jtag_trst_no,
    output logic       srst_no,
    input  logic       jtag_tdo_i,
    output logic       led_o,
    output logic       exit_o,
    output logic       error_o
);

    localparam int unsigned CmdAw = $clog2(CMD_FIFO_DEPTH);
    localparam int unsigned RspAw = $clog2(RSP_FIFO_DEPTH);
    localparam int unsigned CntW  = (TICK_DELAY > 1) ? $clog2(TICK_DELAY) : 1;
    localparam logic [CntW-1:0] HoldLoad = CntW'(TICK_DELAY - 1);

    localparam logic [7:0] ChRead   = 8'h52;  // 'R'
    localparam logic [7:0] ChRstLo  = 8'h72;  // 'r'
    localparam logic [7:0] ChRstHi  = 8'h75;  // 'u'
    localparam logic [7:0] ChBlinkU = 8'h42;  // 'B'
    localparam logic [7:0] ChBlinkL = 8'h62;  // 'b'
    localparam logic [7:0] ChQuit   = 8'h51;  // 'Q'

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StHold
    } state_e;

    state_e r_state, w_state_next;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [7:0]     r_cmd_mem [CMD_FIFO_DEPTH];
    logic [CmdAw:0] r_cmd_wptr;
    logic [CmdAw:0] r_cmd_rptr;
    logic           w_cmd_empty;
    logic           w_cmd_full;
    logic           w_cmd_push;
    logic           w_cmd_pop;
    logic [7:0]     w_cmd_head;

    assign w_cmd_empty = (r_cmd_wptr == r_cmd_rptr);
    assign w_cmd_full  = (r_cmd_wptr[CmdAw] != r_cmd_rptr[CmdAw]) &&
                         (r_cmd_wptr[CmdAw-1:0] == r_cmd_rptr[CmdAw-1:0]);
    assign w_cmd_head  = r_cmd_mem[r_cmd_rptr[CmdAw-1:0]];
    // A full FIFO still accepts a byte in the cycle its head is consumed.
    assign cmd_ready_o = !w_cmd_full || w_cmd_pop;
    assign w_cmd_push  = cmd_valid_i && cmd_ready_o;

    always_ff @(posedge clk_i) begin
        if (w_cmd_push) begin
            r_cmd_mem[r_cmd_wptr[CmdAw-1:0]] <= cmd_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cmd_wptr <= '0;
            r_cmd_rptr <= '0;
        end else begin
            if (w_cmd_push) begin
                r_cmd_wptr <= r_cmd_wptr + 1'b1;
            end
            if (w_cmd_pop) begin
                r_cmd_rptr <= r_cmd_rptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic [7:0]     r_rsp_mem [RSP_FIFO_DEPTH];
    logic [RspAw:0] r_rsp_wptr;
    logic [RspAw:0] r_rsp_rptr;
    logic           w_rsp_empty;
    logic           w_rsp_full;
    logic           w_rsp_push;
    logic           w_rsp_pop;
    logic           w_rsp_room;
    logic [7:0]     w_rsp_char;

    assign w_rsp_empty = (r_rsp_wptr == r_rsp_rptr);
    assign w_rsp_full  = (r_rsp_wptr[RspAw] != r_rsp_rptr[RspAw]) &&
                         (r_rsp_wptr[RspAw-1:0] == r_rsp_rptr[RspAw-1:0]);
    assign rsp_valid_o = !w_rsp_empty;
    assign rsp_data_o  = rsp_valid_o ? r_rsp_mem[r_rsp_rptr[RspAw-1:0]] : 8'h00;
    assign w_rsp_pop   = rsp_valid_o && rsp_ready_i;
    assign w_rsp_room  = !w_rsp_full || w_rsp_pop;
    assign w_rsp_char  = {7'h18, jtag_tdo_i};

    always_ff @(posedge clk_i) begin
        if (w_rsp_push) begin
            r_rsp_mem[r_rsp_wptr[RspAw-1:0]] <= w_rsp_char;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_wptr <= '0;
            r_rsp_rptr <= '0;
        end else begin
            if (w_rsp_push) begin
                r_rsp_wptr <= r_rsp_wptr + 1'b1;
            end
            if (w_rsp_pop) begin
                r_rsp_rptr <= r_rsp_rptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command execution FSM and pin registers
    // ------------------------------------------------------------------
    logic [CntW-1:0] r_cnt, w_cnt_next;
    logic            r_tck, w_tck_next;
    logic            r_tms, w_tms_next;
    logic            r_tdi, w_tdi_next;
    logic            r_trst_n, w_trst_n_next;
    logic            r_srst_n, w_srst_n_next;
    logic            r_exit, w_exit_next;
    logic            r_error, w_error_next;
    logic [1:0]      w_rst_idx;
`ifdef JTAG_BLINK_EN
    logic            r_led, w_led_next;
`endif

    // 'r'..'u' map to {trst,srst} = 0..3
    assign w_rst_idx = w_cmd_head[1:0] - 2'd2;

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_tck_next    = r_tck;
        w_tms_next    = r_tms;
        w_tdi_next    = r_tdi;
        w_trst_n_next = r_trst_n;
        w_srst_n_next = r_srst_n;
        w_exit_next   = r_exit;
        w_error_next  = r_error;
`ifdef JTAG_BLINK_EN
        w_led_next    = r_led;
`endif
        w_cmd_pop     = 1'b0;
        w_rsp_push    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (!w_cmd_empty) begin
                    w_state_next = StExec;
                end
            end
            StExec: begin
                w_cmd_pop    = 1'b1;
                w_state_next = StIdle;
                case (w_cmd_head) inside
                    [8'h30:8'h37]: begin
                        {w_tck_next, w_tms_next, w_tdi_next} = w_cmd_head[2:0];
                        w_cnt_next   = HoldLoad;
                        w_state_next = StHold;
                    end
                    ChRead: begin
                        if (w_rsp_room) begin
                            w_rsp_push = 1'b1;
                        end else begin
                            w_cmd_pop    = 1'b0;
                            w_state_next = StExec;
                        end
                    end
                    [ChRstLo:ChRstHi]: begin
                        w_trst_n_next = ~w_rst_idx[1];
                        w_srst_n_next = ~w_rst_idx[0];
                        w_cnt_next    = HoldLoad;
                        w_state_next  = StHold;
                    end
`ifdef JTAG_BLINK_EN
                    ChBlinkU: w_led_next = 1'b1;
                    ChBlinkL: w_led_next = 1'b0;
`else
                    ChBlinkU, ChBlinkL: ;
`endif
                    ChQuit: w_exit_next = 1'b1;
                    default: w_error_next = 1'b1;
                endcase
            end
            StHold: begin
                if (r_cnt == '0) begin
                    w_state_next = StIdle;
                end else begin
                    w_cnt_next = r_cnt - CntW'(1);
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_tck    <= 1'b0;
            r_tms    <= 1'b1;
            r_tdi    <= 1'b0;
            r_trst_n <= 1'b1;
            r_srst_n <= 1'b1;
            r_exit   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_tck    <= w_tck_next;
            r_tms    <= w_tms_next;
            r_tdi    <= w_tdi_next;
            r_trst_n <= w_trst_n_next;
            r_srst_n <= w_srst_n_next;
            r_exit   <= w_exit_next;
            r_error  <= w_error_next;
        end
    end

`ifdef JTAG_BLINK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_led <= 1'b0;
        end else begin
            r_led <= w_led_next;
        end
    end

    assign led_o = r_led;
`else
    assign led_o = 1'b0;
`endif

    assign jtag_tck_o   = r_tck;
    assign jtag_tms_o   = r_tms;
    assign jtag_tdi_o   = r_tdi;
    assign jtag_trst_no = r_trst_n;
    assign srst_no      = r_srst_n;
    assign exit_o       = r_exit;
    assign error_o      = r_error;

endmodule

// File: tb/tb_jtag_bitbang_bridge.sv
// Self-checking bench for jtag_bitbang_bridge: directed scenarios plus randomized command
// streams checked against a command-timeline reference model.
module tb_jtag_bitbang_bridge;

    localparam int unsigned CmdDepth  = 16;
    localparam int unsigned RspDepth  = 2;
    localparam int          TickDelay = 3;
    localparam int          LogLen    = 8192;
    // {tck,tms,tdi,trst_n,srst_n,led,error,exit}
    localparam logic [7:0]  RstState  = 8'h58;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       cmd_valid_i = 1'b0;
    logic [7:0] cmd_data_i = 8'h00;
    logic       cmd_ready_o;
    logic       rsp_valid_o;
    logic [7:0] rsp_data_o;
    logic       rsp_ready_i = 1'b0;
    logic       jtag_tck_o;
    logic       jtag_tms_o;
    logic       jtag_tdi_o;
    logic       jtag_trst_no;
    logic       srst_no;
    logic       jtag_tdo_i = 1'b0;
    logic       led_o;
    logic       exit_o;
    logic       error_o;

    jtag_bitbang_bridge #(
        .CMD_FIFO_DEPTH(CmdDepth),
        .RSP_FIFO_DEPTH(RspDepth),
        .TICK_DELAY    (TickDelay)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_ready_o (cmd_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_ready_i (rsp_ready_i),
        .jtag_tck_o  (jtag_tck_o),
        .jtag_tms_o  (jtag_tms_o),
        .jtag_tdi_o  (jtag_tdi_o),
        .jtag_trst_no(jtag_trst_no),
        .srst_no     (srst_no),
        .jtag_tdo_i  (jtag_tdo_i),
        .led_o       (led_o),
        .exit_o      (exit_o),
        .error_o     (error_o)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic tdo_rand = 1'b0;
    logic saw_full = 1'b0;

    logic [7:0] log_st [LogLen];
    logic       log_rv [LogLen];
    logic [7:0] log_rd [LogLen];
    logic       tdo_log [LogLen];

    // Model inputs (accepted bytes and their push edges) and outputs
    logic [7:0] q_byte [$];
    int         q_push [$];
    int         q_x [$];
    logic [7:0] q_post [$];
    logic [7:0] m_state;
    int         m_t;

    initial forever #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (cyc < LogLen) begin
            log_st[cyc] <= {jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no, srst_no,
                            led_o, error_o, exit_o};
            log_rv[cyc] <= rsp_valid_o;
            log_rd[cyc] <= rsp_data_o;
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (tdo_rand) jtag_tdo_i = 1'($urandom);
            if (cyc < LogLen) tdo_log[cyc] = jtag_tdo_i;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] cur_st();
        return {jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no, srst_no, led_o, error_o, exit_o};
    endfunction

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        cmd_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        m_state = RstState;
        m_t = 0;
        q_byte.delete();
        q_push.delete();
        @(negedge clk_i);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic push_byte(input logic [7:0] b);
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_data_i = b;
        while (!acc && n < 400) begin
            #1;
            acc = cmd_ready_o;
            if (!acc) saw_full = 1'b1;
            @(negedge clk_i);
            n++;
        end
        cmd_valid_i = 1'b0;
        if (acc) begin
            q_byte.push_back(b);
            q_push.push_back(cyc);
        end else begin
            checks++;
            failures++;
            $display("FAIL push_timeout byte=%h ready=%b required=1", b, cmd_ready_o);
        end
    endtask

    // Each command finishes EXEC at edge x = max(free, push) + 2; pin and reset writes
    // then keep the engine busy TickDelay more cycles.
    task automatic model_eval(output int last_t);
        int t;
        logic [7:0] s;
        logic [7:0] b;
        logic [1:0] idx;
        int x;
        t = m_t;
        s = m_state;
        q_x.delete();
        q_post.delete();
        for (int i = 0; i < q_byte.size(); i++) begin
            b = q_byte[i];
            x = ((t > q_push[i]) ? t : q_push[i]) + 2;
            t = x;
            if (b >= 8'h30 && b <= 8'h37) begin
                s[7:5] = b[2:0];
                t = x + TickDelay;
            end else if (b >= 8'h72 && b <= 8'h75) begin
                idx = 2'(b - 8'h72);
                s[4] = ~idx[1];
                s[3] = ~idx[0];
                t = x + TickDelay;
            end else if (b == 8'h42 || b == 8'h62) begin
`ifdef JTAG_BLINK_EN
                s[2] = (b == 8'h42);
`endif
            end else if (b == 8'h51) begin
                s[0] = 1'b1;
            end else if (b != 8'h52) begin
                s[1] = 1'b1;
            end
            q_x.push_back(x);
            q_post.push_back(s);
        end
        m_t = t;
        m_state = s;
        last_t = t;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (cur_st() !== RstState) begin
            failures++;
            $display("FAIL reset_pins got=%h want=%h", cur_st(), RstState);
        end
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid_o);
        end
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready_o);
        end
    endtask

    task automatic test_pin_steps();
        int off [8] = '{1, 2, 6, 7, 11, 12, 16, 17};
        logic [2:0] exp_p [8] = '{3'b010, 3'b100, 3'b100, 3'b110, 3'b110, 3'b101, 3'b101, 3'b000};
        int e;
        do_reset();
        push_byte(8'h34);
        push_byte(8'h36);
        push_byte(8'h35);
        push_byte(8'h30);
        e = q_push[0];
        repeat (25) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (log_st[e + off[i]][7:5] !== exp_p[i]) begin
                failures++;
                $display("FAIL pin_step[%0d] cyc=+%0d got=%b want=%b", i, off[i],
                         log_st[e + off[i]][7:5], exp_p[i]);
            end
        end
    endtask

    task automatic test_tdo_read();
        logic [8:0] want [3] = '{9'h131, 9'h130, 9'h000};
        do_reset();
        rsp_ready_i = 1'b0;
        tdo_rand = 1'b0;
        jtag_tdo_i = 1'b1;
        push_byte(8'h34);
        push_byte(8'h52);
        repeat (15) @(negedge clk_i);
        jtag_tdo_i = 1'b0;
        push_byte(8'h52);
        repeat (10) @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({rsp_valid_o, rsp_data_o} !== want[i]) begin
                failures++;
                $display("FAIL tdo_read[%0d] got=%b/%h want=%b/%h", i, rsp_valid_o, rsp_data_o,
                         want[i][8], want[i][7:0]);
            end
            rsp_ready_i = 1'b1;
            @(negedge clk_i);
            rsp_ready_i = 1'b0;
        end
    endtask

    task automatic test_rsp_stall();
        logic [7:0] got [$];
        logic [7:0] want [3] = '{8'h31, 8'h31, 8'h30};
        do_reset();
        rsp_ready_i = 1'b0;
        tdo_rand = 1'b0;
        jtag_tdo_i = 1'b1;
        push_byte(8'h52);
        push_byte(8'h52);
        push_byte(8'h52);
        push_byte(8'h37);
        repeat (12) @(negedge clk_i);
        checks++;
        if (rsp_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL stall_rsp_valid got=%b want=1", rsp_valid_o);
        end
        checks++;
        if (cur_st()[7:5] !== 3'b010) begin
            failures++;
            $display("FAIL stall_pins_frozen got=%b want=010", cur_st()[7:5]);
        end
        jtag_tdo_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid_o && rsp_ready_i) got.push_back(rsp_data_o);
            @(negedge clk_i);
        end
        checks++;
        if (got.size() != 3) begin
            failures++;
            $display("FAIL stall_rsp_count got=%0d want=3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                failures++;
                $display("FAIL stall_rsp[%0d] got=%h want=%h", i, got[i], want[i]);
            end
        end
        checks++;
        if (cur_st()[7:5] !== 3'b111) begin
            failures++;
            $display("FAIL stall_resume_pins got=%b want=111", cur_st()[7:5]);
        end
    endtask

    task automatic test_trst_srst();
        logic [7:0] cmd [4] = '{8'h74, 8'h75, 8'h72, 8'h73};
        logic [1:0] want [4] = '{2'b01, 2'b00, 2'b11, 2'b10};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_byte(cmd[i]);
            repeat (8) @(negedge clk_i);
            checks++;
            if ({jtag_trst_no, srst_no} !== want[i]) begin
                failures++;
                $display("FAIL trst_srst[%0d] byte=%h got=%b want=%b", i, cmd[i],
                         {jtag_trst_no, srst_no}, want[i]);
            end
        end
    endtask

    task automatic test_sticky_reset();
        int e;
        int n;
        do_reset();
        push_byte(8'h78);
        repeat (6) @(negedge clk_i);
        checks++;
        if ({error_o, exit_o} !== 2'b10) begin
            failures++;
            $display("FAIL sticky_error got=%b want=10", {error_o, exit_o});
        end
        push_byte(8'h51);
        repeat (6) @(negedge clk_i);
        checks++;
        if ({error_o, exit_o} !== 2'b11) begin
            failures++;
            $display("FAIL sticky_exit got=%b want=11", {error_o, exit_o});
        end
        push_byte(8'h33);
        repeat (8) @(negedge clk_i);
        checks++;
        if ({cur_st()[7:5], error_o, exit_o} !== 5'b01111) begin
            failures++;
            $display("FAIL after_quit got=%b want=01111", {cur_st()[7:5], error_o, exit_o});
        end
        q_push.delete();
        push_byte(8'h36);
        push_byte(8'h31);
        push_byte(8'h32);
        e = q_push[0];
        n = 0;
        while (cyc < e + 3 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (cur_st()[7:5] !== 3'b110) begin
            failures++;
            $display("FAIL mid_hold_pins got=%b want=110", cur_st()[7:5]);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({cur_st(), rsp_valid_o, cmd_ready_o} !== {RstState, 2'b01}) begin
            failures++;
            $display("FAIL async_reset got=%h/%b%b want=%h/01", cur_st(), rsp_valid_o,
                     cmd_ready_o, RstState);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (20) @(negedge clk_i);
        checks++;
        if (cur_st() !== RstState) begin
            failures++;
            $display("FAIL fifo_flushed got=%h want=%h", cur_st(), RstState);
        end
    endtask

    task automatic test_back_to_back();
        int last_t;
        do_reset();
        rsp_ready_i = 1'b1;
        tdo_rand = 1'b0;
        saw_full = 1'b0;
        for (int i = 0; i < 24; i++) push_byte(8'h30 + 8'($urandom_range(0, 7)));
        model_eval(last_t);
        while (cyc < last_t + 4) @(negedge clk_i);
        checks++;
        if (saw_full !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_deassert got=%b want=1", saw_full);
        end
        checks++;
        if (q_x.size() != 24) begin
            failures++;
            $display("FAIL b2b_accepted got=%0d want=24", q_x.size());
        end
        for (int i = 0; i < q_x.size(); i++) begin
            checks++;
            if (log_st[q_x[i]] !== q_post[i]) begin
                failures++;
                $display("FAIL b2b_after[%0d] byte=%h got=%h want=%h", i, q_byte[i],
                         log_st[q_x[i]], q_post[i]);
            end
            checks++;
            if (log_st[q_x[i] - 1] !== ((i == 0) ? RstState : q_post[i-1])) begin
                failures++;
                $display("FAIL b2b_before[%0d] got=%h want=%h", i, log_st[q_x[i] - 1],
                         (i == 0) ? RstState : q_post[i-1]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [20] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                  8'h52, 8'h52, 8'h52, 8'h72, 8'h73, 8'h74, 8'h75,
                                  8'h42, 8'h62, 8'h51, 8'h78, 8'h00};
        int last_t;
        int n_r;
        int seen_r;
        logic [8:0] want_r;
        do_reset();
        rsp_ready_i = 1'b1;
        tdo_rand = 1'b1;
        for (int i = 0; i < 80; i++) begin
            push_byte(pool[$urandom_range(0, 19)]);
            repeat ($urandom_range(0, 6)) @(negedge clk_i);
        end
        model_eval(last_t);
        while (cyc < last_t + 4) @(negedge clk_i);
        tdo_rand = 1'b0;
        n_r = 0;
        for (int i = 0; i < q_x.size(); i++) begin
            checks++;
            if (log_st[q_x[i]] !== q_post[i]) begin
                failures++;
                $display("FAIL rnd_after[%0d] byte=%h got=%h want=%h", i, q_byte[i],
                         log_st[q_x[i]], q_post[i]);
            end
            checks++;
            if (log_st[q_x[i] - 1] !== ((i == 0) ? RstState : q_post[i-1])) begin
                failures++;
                $display("FAIL rnd_before[%0d] byte=%h got=%h want=%h", i, q_byte[i],
                         log_st[q_x[i] - 1], (i == 0) ? RstState : q_post[i-1]);
            end
            if (q_byte[i] == 8'h52) begin
                n_r++;
                want_r = {1'b1, 8'h30 + 8'(tdo_log[q_x[i] - 1])};
                checks++;
                if ({log_rv[q_x[i]], log_rd[q_x[i]]} !== want_r) begin
                    failures++;
                    $display("FAIL rnd_rsp[%0d] got=%b/%h want=%b/%h", i, log_rv[q_x[i]],
                             log_rd[q_x[i]], want_r[8], want_r[7:0]);
                end
            end
        end
        seen_r = 0;
        for (int c = q_push[0]; c < last_t + 4; c++) begin
            if (log_rv[c] === 1'b1) seen_r++;
        end
        checks++;
        if (seen_r != n_r) begin
            failures++;
            $display("FAIL rnd_rsp_count got=%0d want=%0d", seen_r, n_r);
        end
    endtask

    initial begin
        m_state = RstState;
        m_t = 0;
        test_reset();
        test_pin_steps();
        test_tdo_read();
        test_rsp_stall();
        test_trst_srst();
        test_sticky_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
